decode_stage: RTL



---
 rtl/decode_stage.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : instruction decode with RET wait, HALT and illegal detection.
// Rev 1.0 | optional: DECODE_ILLEGAL_CNT_EN adds saturating illegal counter.
// ============================================================================
`default_nettype none

module decode_stage #(
   parameter int INSTR_W = 32,
   parameter int RET_LAT = 3,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instruction,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               flush,
   input  logic               resume,
   output logic [1:0]         reg_file_ren,
   output logic               id_ex_data_input_sel,
   output logic [6:0]         mem_ptr_ctl,
   output logic               main_memory_enable,
   output logic               frame_buffer_enable,
   output logic               call_stack_enable,
   output logic               mem_wen,
   output logic [1:0]         reg_file_wen,
   output logic               stall_fetch,
   output logic               return_in_pipeline,
   output logic               halt,
   output logic               illegal_opcode_exception,
   output logic [CNT_W-1:0]   illegal_cnt
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_RET_WAIT = 2'd1,
      ST_HALTED   = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0] ren;
      logic       imm;
      logic [6:0] ptr;
      logic       mm_en;
      logic       fb_en;
      logic       cs_en;
      logic       mem_wen;
      logic [1:0] wen;
      logic       call;
   } bundle_t;

   localparam logic [3:0] RET_LAT_C = 4'(RET_LAT);

   state_t     state_q, state_d;
   logic [3:0] ret_cnt_q, ret_cnt_d;
   logic       out_valid_q, out_valid_d;
   bundle_t    bundle_q, bundle_d;
   logic       exc_q, exc_d;

   logic [7:0] opcode;
   logic       b22, b21, b20;
   logic [1:0] ptr_sel;
   logic [6:0] ptr_post;
   bundle_t    dec_bundle;
   logic       dec_ret, dec_halt, dec_illegal;
   logic       accept, take;
   logic       unused_bits;

   assign opcode      = instruction[7:0];
   assign b22         = instruction[22];
   assign b21         = instruction[21];
   assign b20         = instruction[20];
   assign ptr_sel     = instruction[19:18];
   assign unused_bits = ^{instruction[INSTR_W-1:23], instruction[17:8]};

   // Post-increment pointer selection, shared by load and store when ptr != 0.
   always_comb begin
      ptr_post = 7'b0000000;
      if (b22) begin
         case (ptr_sel)
            2'b01:   ptr_post = 7'b0010000;
            2'b10:   ptr_post = 7'b0100000;
            2'b11:   ptr_post = 7'b1000000;
            default: ptr_post = 7'b0000000;
         endcase
      end
   end

   always_comb begin
      dec_bundle  = '0;
      dec_ret     = 1'b0;
      dec_halt    = 1'b0;
      dec_illegal = 1'b0;
      case (opcode)
         8'h00: begin
            dec_bundle = '0;
         end
         8'hBC: begin
            dec_bundle.ren = 2'b01;
            dec_bundle.imm = 1'b1;
            dec_bundle.wen = {1'b0, b21};
         end
         8'h80: begin
            dec_bundle.ren = 2'b11;
            dec_bundle.wen = {1'b0, b21};
         end
         8'h8E: begin
            dec_bundle.ren = 2'b11;
            dec_bundle.wen = {b21, b21};
         end
         8'hFB: begin
            dec_bundle.mm_en = b20;
            dec_bundle.fb_en = ~b20;
            dec_bundle.wen   = {1'b0, b21};
            dec_bundle.ptr   = (ptr_sel == 2'b00) ? 7'b0000010 : ptr_post;
         end
         8'hC4: begin
            dec_bundle.mm_en   = b20;
            dec_bundle.fb_en   = ~b20;
            dec_bundle.mem_wen = 1'b1;
            dec_bundle.ptr     = (ptr_sel == 2'b00) ? 7'b0000001 : ptr_post;
         end
         8'h42: begin
            dec_bundle.cs_en   = 1'b1;
            dec_bundle.mem_wen = 1'b1;
            dec_bundle.ptr     = 7'b0001000;
            dec_bundle.call    = 1'b1;
         end
         8'h43: begin
            dec_bundle.cs_en = 1'b1;
            dec_bundle.ptr   = 7'b0000100;
            dec_ret          = 1'b1;
         end
         8'h1F: begin
            dec_halt = 1'b1;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   // A flush in the accept cycle drops the instruction entirely.
   assign take     = accept && !flush;

   always_comb begin
      out_valid_d = out_valid_q;
      bundle_d    = bundle_q;
      exc_d       = 1'b0;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (take) begin
         out_valid_d = 1'b1;
         bundle_d    = dec_bundle;
         exc_d       = dec_illegal;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      ret_cnt_d = ret_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (take && dec_ret) begin
               state_d   = ST_RET_WAIT;
               ret_cnt_d = RET_LAT_C;
            end else if (take && dec_halt) begin
               state_d = ST_HALTED;
            end
         end
         ST_RET_WAIT: begin
            if (flush) begin
               state_d   = ST_RUN;
               ret_cnt_d = 4'd0;
            end else begin
               ret_cnt_d = ret_cnt_q - 4'd1;
               if (ret_cnt_q == 4'd1) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_HALTED: begin
            if (resume) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d   = ST_RUN;
            ret_cnt_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         ret_cnt_q   <= 4'd0;
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
         exc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_cnt_q   <= ret_cnt_d;
         out_valid_q <= out_valid_d;
         bundle_q    <= bundle_d;
         exc_q       <= exc_d;
      end
   end

`ifdef DECODE_ILLEGAL_CNT_EN
   logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

   always_comb begin
      illegal_cnt_d = illegal_cnt_q;
      if (take && dec_illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
         illegal_cnt_d = illegal_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_cnt_q <= '0;
      end else begin
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign illegal_cnt = illegal_cnt_q;
`else
   assign illegal_cnt = '0;
`endif

   assign out_valid                = out_valid_q;
   assign reg_file_ren             = bundle_q.ren;
   assign id_ex_data_input_sel     = bundle_q.imm;
   assign mem_ptr_ctl              = bundle_q.ptr;
   assign main_memory_enable       = bundle_q.mm_en;
   assign frame_buffer_enable      = bundle_q.fb_en;
   assign call_stack_enable        = bundle_q.cs_en;
   assign mem_wen                  = bundle_q.mem_wen;
   assign reg_file_wen             = bundle_q.wen;
   assign stall_fetch              = (state_q == ST_RET_WAIT) || (out_valid_q && bundle_q.call);
   assign return_in_pipeline       = (state_q == ST_RET_WAIT);
   assign halt                     = (state_q == ST_HALTED);
   assign illegal_opcode_exception = exc_q;

endmodule

`default_nettype wire
